// File: rtl/exu_gpr_if.sv
// EXU GPR interface: two read ports, one write port and a ready flag.
// The execute-unit handlers drive it as master and the register file responds as slave.
interface exu_gpr_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned AW   = 5
);
    logic [AW-1:0]   ra1;
    logic [XLEN-1:0] rd1;
    logic [AW-1:0]   ra2;
    logic [XLEN-1:0] rd2;
    logic            wen;
    logic [AW-1:0]   wa;
    logic [XLEN-1:0] wd;
    logic            rdy;

    modport master (
        output ra1, ra2, wen, wa, wd,
        input  rd1, rd2, rdy
    );

    modport slave (
        input  ra1, ra2, wen, wa, wd,
        output rd1, rd2, rdy
    );
endinterface

// File: rtl/exu_gpr_file.sv
// RV32I general-purpose register file: x0 reads as zero, 2R/1W, optional write-to-read bypass.
// After reset a sequencer zeroes entries 1..31 one per cycle, so the array itself needs no reset.
module exu_gpr_file #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned AW         = 5,
    parameter bit          BYPASS     = 1'b1,
    parameter bit          INIT_CLEAR = 1'b1
) (
    input  logic      clk,
    input  logic      rst,
    exu_gpr_if.slave  gpr
);
    localparam int unsigned NREG     = 1 << AW;
    localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

    typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   clr_idx_q, clr_idx_d;
    logic            rdy_q, rdy_d;

    logic            mem_we;
    logic [AW-1:0]   mem_wa;
    logic [XLEN-1:0] mem_wd;
    logic [XLEN-1:0] mem [NREG];

    // State register; only the sequencer state is reset, never the array.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (INIT_CLEAR) begin
                state_q <= CLEAR;
            end else begin
                state_q <= RUN;
            end
            clr_idx_q <= AW'(1);
            rdy_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            rdy_q     <= rdy_d;
        end
    end

    // Next-state logic; rdy rises on the edge that clears the last entry.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        rdy_d     = rdy_q;
        case (state_q)
            CLEAR: begin
                clr_idx_d = clr_idx_q + AW'(1);
                if (clr_idx_q == LAST_IDX) begin
                    state_d = RUN;
                    rdy_d   = 1'b1;
                end
            end
            RUN: begin
                rdy_d = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Output logic: array write port selection and combinational read ports.
    always_comb begin
        mem_we  = 1'b0;
        mem_wa  = clr_idx_q;
        mem_wd  = '0;
        gpr.rd1 = '0;
        gpr.rd2 = '0;
        case (state_q)
            CLEAR: begin
                mem_we = !rst;
            end
            RUN: begin
                mem_we = !rst && gpr.wen && (gpr.wa != '0);
                mem_wa = gpr.wa;
                mem_wd = gpr.wd;
                if (gpr.ra1 != '0) begin
                    if (BYPASS && gpr.wen && (gpr.wa == gpr.ra1)) begin
                        gpr.rd1 = gpr.wd;
                    end else begin
                        gpr.rd1 = mem[gpr.ra1];
                    end
                end
                if (gpr.ra2 != '0) begin
                    if (BYPASS && gpr.wen && (gpr.wa == gpr.ra2)) begin
                        gpr.rd2 = gpr.wd;
                    end else begin
                        gpr.rd2 = mem[gpr.ra2];
                    end
                end
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
    end

    // Storage array without reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    assign gpr.rdy = rdy_q;

endmodule

// File: tb/tb_exu_gpr_file.sv
// Directed bench for exu_gpr_file: a BYPASS=1 and a BYPASS=0 instance share the same stimulus.
module tb_exu_gpr_file;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fails  = 0;

    exu_gpr_if #(.XLEN(32), .AW(5)) bus_b ();
    exu_gpr_if #(.XLEN(32), .AW(5)) bus_n ();

    assign bus_n.ra1 = bus_b.ra1;
    assign bus_n.ra2 = bus_b.ra2;
    assign bus_n.wen = bus_b.wen;
    assign bus_n.wa  = bus_b.wa;
    assign bus_n.wd  = bus_b.wd;

    exu_gpr_file #(.XLEN(32), .AW(5), .BYPASS(1'b1), .INIT_CLEAR(1'b1)) dut_b (
        .clk (clk),
        .rst (rst),
        .gpr (bus_b.slave)
    );

    exu_gpr_file #(.XLEN(32), .AW(5), .BYPASS(1'b0), .INIT_CLEAR(1'b1)) dut_n (
        .clk (clk),
        .rst (rst),
        .gpr (bus_n.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus_b.ra1 = '0;
        bus_b.ra2 = '0;
        bus_b.wen = 1'b0;
        bus_b.wa  = '0;
        bus_b.wd  = '0;
    endtask

    // Counts cycles until both instances raise rdy, bounded at 40.
    task automatic wait_rdy(output int cycles);
        cycles = 0;
        while (!(bus_b.rdy && bus_n.rdy) && cycles < 40) begin
            step();
            cycles++;
        end
    endtask

    task automatic test_reset();
        int cycles;
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        n_checks++;
        if (bus_b.rdy !== 1'b0 || bus_n.rdy !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_rdy: got %b/%b expected 0/0", bus_b.rdy, bus_n.rdy);
        end
        rst = 1'b0;
        bus_b.ra1 = 5'd5;
        bus_b.ra2 = 5'd31;
        #1;
        n_checks++;
        if (bus_b.rd1 !== 32'h0 || bus_b.rd2 !== 32'h0) begin
            n_fails++;
            $display("FAIL clear_reads_zero: got %h/%h expected 0/0", bus_b.rd1, bus_b.rd2);
        end
        wait_rdy(cycles);
        n_checks++;
        if (cycles != 31) begin
            n_fails++;
            $display("FAIL clear_length: got %0d cycles expected 31", cycles);
        end
        for (int a = 1; a < 32; a++) begin
            bus_b.ra1 = 5'(a);
            #1;
            n_checks++;
            if (bus_b.rd1 !== 32'h0 || bus_n.rd1 !== 32'h0) begin
                n_fails++;
                $display("FAIL cleared_x%0d: got %h/%h expected 00000000", a, bus_b.rd1, bus_n.rd1);
            end
        end
        idle_inputs();
    endtask

    task automatic test_write_read();
        bus_b.wen = 1'b1;
        bus_b.wa  = 5'd5;
        bus_b.wd  = 32'hDEADBEEF;
        step();
        bus_b.wen = 1'b0;
        bus_b.ra1 = 5'd5;
        bus_b.ra2 = 5'd6;
        #1;
        n_checks++;
        if (bus_b.rd1 !== 32'hDEADBEEF || bus_n.rd1 !== 32'hDEADBEEF) begin
            n_fails++;
            $display("FAIL write_read_x5: got %h/%h expected deadbeef", bus_b.rd1, bus_n.rd1);
        end
        n_checks++;
        if (bus_b.rd2 !== 32'h0 || bus_n.rd2 !== 32'h0) begin
            n_fails++;
            $display("FAIL write_read_x6: got %h/%h expected 00000000", bus_b.rd2, bus_n.rd2);
        end
        idle_inputs();
    endtask

    task automatic test_x0();
        bus_b.wen = 1'b1;
        bus_b.wa  = 5'd0;
        bus_b.wd  = 32'hFFFFFFFF;
        bus_b.ra1 = 5'd0;
        bus_b.ra2 = 5'd0;
        #1;
        n_checks++;
        if (bus_b.rd1 !== 32'h0 || bus_b.rd2 !== 32'h0 || bus_n.rd1 !== 32'h0 || bus_n.rd2 !== 32'h0) begin
            n_fails++;
            $display("FAIL x0_same_cycle: got %h/%h expected 00000000", bus_b.rd1, bus_b.rd2);
        end
        step();
        bus_b.wen = 1'b0;
        #1;
        n_checks++;
        if (bus_b.rd1 !== 32'h0 || bus_b.rd2 !== 32'h0 || bus_n.rd1 !== 32'h0 || bus_n.rd2 !== 32'h0) begin
            n_fails++;
            $display("FAIL x0_next_cycle: got %h/%h expected 00000000", bus_b.rd1, bus_b.rd2);
        end
        idle_inputs();
    endtask

    task automatic test_bypass();
        bus_b.wen = 1'b1;
        bus_b.wa  = 5'd7;
        bus_b.wd  = 32'h11111111;
        step();
        bus_b.wd  = 32'h22222222;
        bus_b.ra1 = 5'd7;
        bus_b.ra2 = 5'd7;
        #1;
        n_checks++;
        if (bus_b.rd1 !== 32'h22222222 || bus_b.rd2 !== 32'h22222222) begin
            n_fails++;
            $display("FAIL bypass_on: got %h/%h expected 22222222", bus_b.rd1, bus_b.rd2);
        end
        n_checks++;
        if (bus_n.rd1 !== 32'h11111111 || bus_n.rd2 !== 32'h11111111) begin
            n_fails++;
            $display("FAIL bypass_off: got %h/%h expected 11111111", bus_n.rd1, bus_n.rd2);
        end
        step();
        bus_b.wen = 1'b0;
        #1;
        n_checks++;
        if (bus_b.rd1 !== 32'h22222222 || bus_n.rd2 !== 32'h22222222) begin
            n_fails++;
            $display("FAIL bypass_next: got %h/%h expected 22222222", bus_b.rd1, bus_n.rd2);
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        bus_b.wen = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus_b.wa = 5'(10 + i);
            bus_b.wd = 32'hC0DE0000 + 32'(i);
            step();
        end
        bus_b.wen = 1'b0;
        bus_b.ra1 = 5'd10;
        bus_b.ra2 = 5'd12;
        #1;
        n_checks++;
        if (bus_b.rd1 !== 32'hC0DE0000 || bus_n.rd2 !== 32'hC0DE0002) begin
            n_fails++;
            $display("FAIL b2b_x10_x12: got %h/%h expected c0de0000/c0de0002", bus_b.rd1, bus_n.rd2);
        end
        bus_b.ra1 = 5'd11;
        #1;
        n_checks++;
        if (bus_n.rd1 !== 32'hC0DE0001) begin
            n_fails++;
            $display("FAIL b2b_x11: got %h expected c0de0001", bus_n.rd1);
        end
        idle_inputs();
    endtask

    task automatic test_write_during_clear();
        int cycles;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) step();
        bus_b.wen = 1'b1;
        bus_b.wa  = 5'd3;
        bus_b.wd  = 32'hA5A5A5A5;
        bus_b.ra1 = 5'd3;
        #1;
        n_checks++;
        if (bus_b.rd1 !== 32'h0 || bus_b.rdy !== 1'b0) begin
            n_fails++;
            $display("FAIL clear_ignores_bypass: got rd=%h rdy=%b expected 00000000/0", bus_b.rd1, bus_b.rdy);
        end
        step();
        bus_b.wen = 1'b0;
        wait_rdy(cycles);
        n_checks++;
        if (cycles != 20) begin
            n_fails++;
            $display("FAIL clear_remaining: got %0d cycles expected 20", cycles);
        end
        bus_b.ra1 = 5'd3;
        bus_b.ra2 = 5'd5;
        #1;
        n_checks++;
        if (bus_b.rd1 !== 32'h0 || bus_n.rd1 !== 32'h0) begin
            n_fails++;
            $display("FAIL clear_write_dropped: got %h/%h expected 00000000", bus_b.rd1, bus_n.rd1);
        end
        n_checks++;
        if (bus_b.rd2 !== 32'h0) begin
            n_fails++;
            $display("FAIL reclear_x5: got %h expected 00000000", bus_b.rd2);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_clear();
        int cycles;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus_b.rdy !== 1'b0) begin
            n_fails++;
            $display("FAIL mid_clear_rdy: got %b expected 0", bus_b.rdy);
        end
        wait_rdy(cycles);
        n_checks++;
        if (cycles != 31) begin
            n_fails++;
            $display("FAIL mid_clear_length: got %0d cycles expected 31", cycles);
        end
        bus_b.wen = 1'b1;
        bus_b.wa  = 5'd31;
        bus_b.wd  = 32'h12345678;
        step();
        bus_b.wen = 1'b0;
        bus_b.ra2 = 5'd31;
        #1;
        n_checks++;
        if (bus_b.rd2 !== 32'h12345678 || bus_n.rd2 !== 32'h12345678) begin
            n_fails++;
            $display("FAIL mid_clear_x31: got %h/%h expected 12345678", bus_b.rd2, bus_n.rd2);
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_write_read();
        test_x0();
        test_bypass();
        test_back_to_back();
        test_write_during_clear();
        test_reset_mid_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
